icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, read-only instruction cache between the fetch stage's PC and a slower backing instruction memory. It returns the instruction word on a hit in the same cycle. On a miss it raises a stall to the pipeline, refills the whole line from backing memory one word per beat, then resumes. It also supports a single-cycle invalidate for fence.i or program reload.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction/word width
- ADDR_WIDTH, 32, PC width
- SETS, 64, number of lines; power of two
- WORDS_PER_LINE, 4, words per line; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- pc_i  in  ADDR_WIDTH  fetch address; bits [1:0] ignored
- req_i  in  1  fetch request valid this cycle
- flush_i  in  1  invalidate all lines
- instr_o  out  DATA_WIDTH  instruction at pc_i; valid when req_i & ~stall_o
- stall_o  out  1  fetch must hold PC (feeds StallF OR-term)
- mem_req_o  out  1  refill request to backing memory
- mem_addr_o  out  ADDR_WIDTH  word address of current refill beat
- mem_rdata_i  in  DATA_WIDTH  refill data
- mem_valid_i  in  1  mem_rdata_i valid; one beat accepted per high cycle
- hit_count_o  out  32  hit counter (see Configuration)
- miss_count_o  out  32  miss counter (see Configuration)

## Operation
- Address split:
  - offset = pc[1+log2(WPL):2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Storage:
  - tag array, valid bit per line, data array of SETS×WPL words
  - all arrays are flops with asynchronous read
- FSM states: IDLE, REFILL.
- IDLE:
  - hit = req_i & valid[index] & (tag_array[index]==tag); instr_o = data[index][offset]; stall_o=0.
  - miss = req_i & ~hit:
    - stall_o=1 combinationally
    - latch line base address (pc with offset and byte bits zeroed)
    - beat counter ← 0
    - next state REFILL
  - req_i=0: stall_o=0, no state change; instr_o don't-care.
- REFILL:
  - stall_o=1; mem_req_o=1; mem_addr_o = latched base + 4·beat.
  - On mem_valid_i: write mem_rdata_i to data[idx][beat], beat++.
  - On the last beat (beat==WPL-1 & mem_valid_i): write tag and set valid, then next state IDLE.
  - pc_i and req_i are ignored during REFILL; the pipeline holds PC.
- Next cycle after a refill, IDLE re-looks up pc_i. The result is a hit and stall_o drops.
- The backing memory protocol: mem_valid_i is only meaningful while mem_req_o=1. Dropping mem_req_o cancels the outstanding request.
- flush_i:
  - clears all valid bits at the next edge.
  - In REFILL: aborts the refill, mem_req_o drops next cycle, the line is not validated, state returns to IDLE.
  - In IDLE with a same-cycle miss: the flush takes priority and no refill starts. stall_o stays 1 that cycle and the lookup is retried.
- Simultaneous hit and flush in IDLE: instr_o is still returned that cycle, and the line is invalid afterward.

## Timing
- Reset values:
  - state IDLE, all valid=0, beat=0
  - mem_req_o=0, mem_addr_o=0, stall_o=0 (req_i=0)
  - counters 0
- Hit latency: 0 cycles, combinational from pc_i.
- Miss penalty: 1 (detect) + Σ beat wait cycles + 1 (re-lookup). With mem_valid_i permanently high and WPL=4: stall_o is high for 5 cycles, and the instruction is available on the 6th cycle.
- mem_addr_o is registered. It is stable throughout each beat and updates the edge after mem_valid_i.
- Reset mid-refill: immediate return to IDLE, mem_req_o=0, all lines invalid.

## Configuration
- ICACHE_STATS_EN defined:
  - hit_count_o increments on each IDLE hit.
  - miss_count_o increments on each miss detection (IDLE→REFILL).
  - Both counters are 32-bit, saturate at 0xFFFFFFFF, and are cleared by rst only.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- Cold miss:
  - Stimulus: after reset, req_i=1, pc=0x100, mem_valid_i always high.
  - Expect: stall_o high for 5 cycles; mem_addr_o 0x100,0x104,0x108,0x10C; instr_o = word@0x100 on cycle 6 with stall_o=0.
- Spatial hit:
  - Stimulus: pc=0x104, 0x108, 0x10C in consecutive cycles after that refill.
  - Expect: stall_o=0 every cycle; correct words returned.
- Conflict eviction:
  - Stimulus: pc=0x100 then pc = 0x100 + SETS·WPL·4 (same index).
  - Expect: a miss and refill on the second access, then 0x100 misses again.
- Slow memory:
  - Stimulus: mem_valid_i high every 3rd cycle.
  - Expect: beat advances only on valid, and stall_o stays high until one cycle after the 4th beat.
- Flush mid-refill:
  - Stimulus: assert flush_i after beat 1.
  - Expect: mem_req_o=0 next cycle, state IDLE, the same pc misses again, and previously valid lines miss.
- With ICACHE_STATS_EN:
  - Stimulus: 1 miss followed by 3 hits.
  - Expect: miss_count_o=1, hit_count_o=4 (includes the post-refill hit).

Source files
------------

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with whole-line refill
// Optional hit/miss counters are built only when ICACHE_STATS_EN is defined.
module icache_direct #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic                  req_i,
    input  logic                  flush_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_valid_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);
    localparam int OFF_W    = $clog2(WORDS_PER_LINE);
    localparam int IDX_W    = $clog2(SETS);
    localparam int LINE_LSB = 2 + OFF_W;
    localparam int LINE_W   = ADDR_WIDTH - LINE_LSB;
    localparam int TAG_W    = LINE_W - IDX_W;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                r_state, w_next;
    logic [SETS-1:0]       r_valid;
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [DATA_WIDTH-1:0] r_data [SETS*WORDS_PER_LINE];
    logic [LINE_W-1:0]     r_line;
    logic [OFF_W-1:0]      r_beat;
    logic [ADDR_WIDTH-1:0] r_mem_addr;

    logic [OFF_W-1:0]      w_off;
    logic [IDX_W-1:0]      w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [IDX_W-1:0]      w_ref_idx;
    logic                  w_hit, w_miss, w_start, w_beat_acc, w_last;
    logic                  w_unused_pc;

    assign w_off       = pc_i[LINE_LSB-1:2];
    assign w_idx       = pc_i[LINE_LSB+IDX_W-1:LINE_LSB];
    assign w_tag       = pc_i[ADDR_WIDTH-1:LINE_LSB+IDX_W];
    assign w_unused_pc = ^pc_i[1:0];
    assign w_ref_idx   = r_line[IDX_W-1:0];

    assign w_hit      = req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss     = req_i & ~w_hit;
    // A flush on the miss cycle wins: the lookup is simply retried next cycle.
    assign w_start    = (r_state == IDLE) & w_miss & ~flush_i;
    assign w_beat_acc = (r_state == REFILL) & mem_valid_i;
    assign w_last     = w_beat_acc & (r_beat == OFF_W'(WORDS_PER_LINE - 1));

    assign instr_o    = r_data[{w_idx, w_off}];
    assign mem_addr_o = r_mem_addr;

    always_comb begin
        w_next    = r_state;
        stall_o   = 1'b0;
        mem_req_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_miss) begin
                    stall_o = 1'b1;
                    if (!flush_i) w_next = REFILL;
                end
            end
            REFILL: begin
                stall_o   = 1'b1;
                mem_req_o = 1'b1;
                if (flush_i || w_last) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_line     <= '0;
            r_beat     <= '0;
            r_mem_addr <= '0;
        end else begin
            r_state <= w_next;
            if (flush_i)     r_valid            <= '0;
            else if (w_last) r_valid[w_ref_idx] <= 1'b1;
            if (w_start) begin
                r_line     <= pc_i[ADDR_WIDTH-1:LINE_LSB];
                r_beat     <= '0;
                r_mem_addr <= {pc_i[ADDR_WIDTH-1:LINE_LSB], LINE_LSB'(0)};
            end else if (w_beat_acc) begin
                r_beat     <= r_beat + 1'b1;
                r_mem_addr <= r_mem_addr + ADDR_WIDTH'(4);
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (w_beat_acc) r_data[{w_ref_idx, r_beat}] <= mem_rdata_i;
        if (w_last)     r_tag[w_ref_idx]            <= r_line[LINE_W-1:IDX_W];
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt, r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && w_hit && (r_hit_cnt != 32'hFFFF_FFFF))
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_start && (r_miss_cnt != 32'hFFFF_FFFF))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count_o  = r_hit_cnt;
    assign miss_count_o = r_miss_cnt;
`else
    assign hit_count_o  = 32'd0;
    assign miss_count_o = 32'd0;
`endif
endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed self-checking bench for icache_direct
module tb_icache_direct;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        req_i, flush_i, mem_valid_i;
    logic [31:0] instr_o, mem_addr_o, mem_rdata_i, hit_count_o, miss_count_o;
    logic        stall_o, mem_req_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    icache_direct dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .req_i(req_i), .flush_i(flush_i),
        .instr_o(instr_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .mem_valid_i(mem_valid_i),
        .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign mem_rdata_i = word(mem_addr_o);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input int exp_stalls);
        int stalls = 0;
        bit done = 0;
        req_i = 1'b1; pc_i = a; flush_i = 1'b0; mem_valid_i = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall_o) done = 1;
            else begin stalls++; step(); end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL fetch_timeout pc=%h stall still high", a);
        end else begin
            n_checks++;
            if (instr_o !== word(a)) begin
                n_fail++;
                $display("FAIL fetch_instr pc=%h got=%h exp=%h", a, instr_o, word(a));
            end
            n_checks++;
            if (stalls != exp_stalls) begin
                n_fail++;
                $display("FAIL fetch_stalls pc=%h got=%0d exp=%0d", a, stalls, exp_stalls);
            end
            exp_hits++;
            if (stalls > 0) exp_miss++;
        end
        step();
    endtask

    task automatic check_counters();
        logic [31:0] eh, em;
`ifdef ICACHE_STATS_EN
        eh = 32'(exp_hits); em = 32'(exp_miss);
`else
        eh = 32'd0; em = 32'd0;
`endif
        n_checks++;
        if (hit_count_o !== eh) begin
            n_fail++; $display("FAIL hit_count got=%0d exp=%0d", hit_count_o, eh);
        end
        n_checks++;
        if (miss_count_o !== em) begin
            n_fail++; $display("FAIL miss_count got=%0d exp=%0d", miss_count_o, em);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_i = 1'b0; flush_i = 1'b0; mem_valid_i = 1'b0; pc_i = 32'h0;
        #1;
        n_checks++;
        if ({stall_o, mem_req_o, mem_addr_o} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs stall=%b req=%b addr=%h exp 0/0/0", stall_o, mem_req_o, mem_addr_o);
        end
        check_counters();
        step(); step();
        rst = 1'b1;
    endtask

    task automatic test_cold_miss();
        req_i = 1'b1; pc_i = 32'h100; mem_valid_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (stall_o !== (c <= 5)) begin
                n_fail++; $display("FAIL cold_stall cycle=%0d got=%b exp=%b", c, stall_o, c <= 5);
            end
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (mem_addr_o !== 32'h100 + 32'(4 * (c - 2)) || mem_req_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL cold_addr cycle=%0d got=%h req=%b exp=%h", c, mem_addr_o, mem_req_o, 32'h100 + 32'(4 * (c - 2)));
                end
            end
            if (c == 6) begin
                n_checks++;
                if (instr_o !== word(32'h100)) begin
                    n_fail++; $display("FAIL cold_instr got=%h exp=%h", instr_o, word(32'h100));
                end
            end
            step();
        end
        exp_miss++; exp_hits++;
    endtask

    task automatic test_spatial_hit();
        fetch(32'h104, 0);
        fetch(32'h108, 0);
        fetch(32'h10C, 0);
    endtask

    task automatic test_conflict();
        fetch(32'h500, 5);
        fetch(32'h100, 5);
        fetch(32'h104, 0);
    endtask

    task automatic test_slow_memory();
        int nv = 0;
        req_i = 1'b1; pc_i = 32'h200;
        for (int c = 1; c <= 14; c++) begin
            mem_valid_i = (c >= 4) && (c % 3 == 1);
            @(negedge clk);
            n_checks++;
            if (stall_o !== (c <= 13)) begin
                n_fail++; $display("FAIL slow_stall cycle=%0d got=%b exp=%b", c, stall_o, c <= 13);
            end
            if (c >= 2 && c <= 13) begin
                n_checks++;
                if (mem_addr_o !== 32'h200 + 32'(4 * nv)) begin
                    n_fail++; $display("FAIL slow_addr cycle=%0d got=%h exp=%h", c, mem_addr_o, 32'h200 + 32'(4 * nv));
                end
            end
            if (c == 14) begin
                n_checks++;
                if (instr_o !== word(32'h200)) begin
                    n_fail++; $display("FAIL slow_instr got=%h exp=%h", instr_o, word(32'h200));
                end
            end
            if (mem_valid_i) nv++;
            step();
        end
        mem_valid_i = 1'b1;
        exp_miss++; exp_hits++;
    endtask

    task automatic test_flush_refill();
        req_i = 1'b1; pc_i = 32'h300; mem_valid_i = 1'b1;
        step(); step(); step();
        flush_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h308) begin
            n_fail++; $display("FAIL flush_pre req=%b addr=%h exp 1/00000308", mem_req_o, mem_addr_o);
        end
        step();
        flush_i = 1'b0; req_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_abort req=%b stall=%b exp 0/0", mem_req_o, stall_o);
        end
        step();
        exp_miss++;
        fetch(32'h300, 5);
        fetch(32'h100, 5);
        fetch(32'h200, 5);
    endtask

    task automatic test_flush_idle();
        req_i = 1'b1; pc_i = 32'h400; flush_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_miss_stall got=%b exp=1", stall_o);
        end
        step();
        req_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_miss_norefill got=%b exp=0", mem_req_o);
        end
        step();
        fetch(32'h400, 5);
        req_i = 1'b1; pc_i = 32'h404; flush_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (stall_o !== 1'b0 || instr_o !== word(32'h404)) begin
            n_fail++; $display("FAIL flush_hit got stall=%b instr=%h exp 0/%h", stall_o, instr_o, word(32'h404));
        end
        exp_hits++;
        step();
        fetch(32'h404, 5);
    endtask

    task automatic test_reset_mid_refill();
        req_i = 1'b0;
        step();
        @(negedge clk);
        check_counters();
        step();
        req_i = 1'b1; pc_i = 32'h600; mem_valid_i = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_refill req=%b addr=%h exp 0/0", mem_req_o, mem_addr_o);
        end
        exp_hits = 0; exp_miss = 0;
        check_counters();
        step();
        rst = 1'b1;
        fetch(32'h100, 5);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_spatial_hit();
        test_conflict();
        test_slow_memory();
        test_flush_refill();
        test_flush_idle();
        test_reset_mid_refill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
